level_frame_ctrl: RTL

Packet controller between the UART receiver and the VU-meter display logic. It consumes the receiver's byte stream, parses 4-byte level frames (sync, channel, level, check), and updates the left and right level registers that drive the LED bars. It also recovers from corrupt, truncated or stalled frames. Only validated frames ever reach the display.

---
 rtl/level_frame_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/level_frame_ctrl.sv
// level_frame_ctrl
// Parses 4-byte level frames (sync, channel, level, check) from the UART
// receiver byte stream. It updates the left/right VU-meter level registers
// only for frames that pass validation. Corrupt, truncated or stalled frames
// are aborted with a one-cycle frame_error pulse.
//
// Ports:
//   clk_board    in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   enable       in   low forces IDLE and ignores receiver strobes
//   rx_data[7:0] in   received byte, valid with rx_load
//   rx_load      in   one-cycle strobe, new byte on rx_data
//   rx_error     in   one-cycle strobe, receiver framing error
//   level_left   out  left-channel level register
//   level_right  out  right-channel level register
//   update       out  one-cycle pulse, level register(s) written
//   frame_error  out  one-cycle pulse, frame aborted
//   frame_count  out  accepted-frame count, wraps at 8'hFF
//
// state | meaning
// IDLE  | waiting for sync_byte, stray bytes dropped silently
// CHAN  | sync seen, next byte selects channel (0 left, 1 right, 2 both)
// LEVEL | channel valid, next byte is the level value
// CHECK | next byte must equal chan ^ lvl for the frame to be accepted
module level_frame_ctrl #(
  parameter int unsigned board_freq    = 64,
  parameter int unsigned baud_rate     = 1,
  parameter logic [7:0]  sync_byte     = 8'hA5,
  parameter int unsigned timeout_bytes = 4
) (
  input  logic       clk_board,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] rx_data,
  input  logic       rx_load,
  input  logic       rx_error,
  output logic [7:0] level_left,
  output logic [7:0] level_right,
  output logic       update,
  output logic       frame_error,
  output logic [7:0] frame_count
);

  // Computed in 64 bits so realistic clock rates do not overflow.
  localparam longint unsigned TIMEOUT_CYCLES =
    (64'(timeout_bytes) * 64'd10 * 64'(board_freq)) / 64'(baud_rate);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CHAN, LEVEL, CHECK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       chan_q, chan_d;
  logic [7:0]       lvl_q, lvl_d;
  logic [7:0]       left_d, right_d, count_d;
  logic             update_d, err_d;
  logic             timeout;

  always_ff @(posedge clk_board or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      chan_q      <= 8'h00;
      lvl_q       <= 8'h00;
      level_left  <= 8'h00;
      level_right <= 8'h00;
      frame_count <= 8'h00;
      update      <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      chan_q      <= chan_d;
      lvl_q       <= lvl_d;
      level_left  <= left_d;
      level_right <= right_d;
      frame_count <= count_d;
      update      <= update_d;
      frame_error <= err_d;
    end
  end

  assign timeout = (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    chan_d   = chan_q;
    lvl_d    = lvl_q;
    left_d   = level_left;
    right_d  = level_right;
    count_d  = frame_count;
    update_d = 1'b0;
    err_d    = 1'b0;

    // Priority: enable, receiver error, byte load, then timeout. A load on
    // the timeout cycle therefore keeps the frame alive.
    if (!enable) begin
      state_d = IDLE;
    end else if (rx_error && (state_q != IDLE)) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (rx_load) begin
      case (state_q)
        IDLE: begin
          if (rx_data == sync_byte) state_d = CHAN;
        end
        CHAN: begin
          chan_d = rx_data;
          if (rx_data <= 8'h02) begin
            state_d = LEVEL;
          end else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        LEVEL: begin
          lvl_d   = rx_data;
          state_d = CHECK;
        end
        CHECK: begin
          state_d = IDLE;
          if (rx_data == (chan_q ^ lvl_q)) begin
            update_d = 1'b1;
            count_d  = frame_count + 8'd1;
            if (chan_q != 8'h01) left_d  = lvl_q;
            if (chan_q != 8'h00) right_d = lvl_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if ((state_q != IDLE) && timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end

    // Any byte restarts the inter-byte window; IDLE parks the counter at 0.
    if ((state_d == IDLE) || rx_load) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule
